// File: rtl/add_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : add_serial_ctrl (with helpers fulladd6, mux)
// Description : Accepts one operand set {a, b, c_in} per frame over a
//               valid/ready handshake. The operands are held in registers that
//               feed a 6-bit ripple adder. The controller then steps a 7:1 mux
//               select from 0 to 6, which streams SUM[0..5] and then C_OUT
//               LSB-first over a 1-bit valid/ready serial port.
//               After the last bit, an optional idle gap of FRAME_GAP cycles
//               runs before a new frame is accepted.
// Ports       : clk, rst_n (async, active low)
//               start_valid/start_ready, a[5:0], b[5:0], c_in : operand input
//               abort                                        : cancel frame
//               ser_valid/ser_ready, ser_data, ser_last       : serial output
//               sel_q[2:0]                                    : current select
//               frame_cnt[7:0]                                : completed frames
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// fulladd6 : 6-bit ripple-carry adder
//   a, b  : addends      c_in : carry in
//   sum   : 6-bit sum    c_out: carry out
// ----------------------------------------------------------------------------
module fulladd6 (
  input  logic [5:0] a,
  input  logic [5:0] b,
  input  logic       c_in,
  output logic [5:0] sum,
  output logic       c_out
);

  logic [6:0] w_carry;

  assign w_carry[0] = c_in;

  for (genvar i = 0; i < 6; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
    assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
  end

  assign c_out = w_carry[6];

endmodule

// ----------------------------------------------------------------------------
// mux : 7:1 single-bit multiplexer
//   d   : data inputs    sel : select (7 is unused and yields 0)
//   y   : selected bit
// ----------------------------------------------------------------------------
module mux (
  input  logic [6:0] d,
  input  logic [2:0] sel,
  output logic       y
);

  always_comb begin
    y = 1'b0;
    case (sel)
      3'd0:    y = d[0];
      3'd1:    y = d[1];
      3'd2:    y = d[2];
      3'd3:    y = d[3];
      3'd4:    y = d[4];
      3'd5:    y = d[5];
      3'd6:    y = d[6];
      default: y = 1'b0;
    endcase
  end

endmodule

// ----------------------------------------------------------------------------
// add_serial_ctrl : frame sequencer (see file header)
// ----------------------------------------------------------------------------
module add_serial_ctrl #(
  parameter int unsigned FRAME_GAP = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic [5:0] a,
  input  logic [5:0] b,
  input  logic       c_in,
  input  logic       abort,
  output logic       ser_valid,
  input  logic       ser_ready,
  output logic       ser_data,
  output logic       ser_last,
  output logic [2:0] sel_q,
  output logic [7:0] frame_cnt
);

  localparam bit         c_has_gap  = (FRAME_GAP != 0);
  // gap_cnt counts FRAME_GAP-1 down to 0, so GAP lasts exactly FRAME_GAP cycles
  localparam logic [3:0] c_gap_load = c_has_gap ? 4'(FRAME_GAP - 1) : 4'd0;
  localparam logic [2:0] c_last_sel = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic [5:0] r_a;
  logic [5:0] r_b;
  logic       r_c_in;
  logic [2:0] r_sel;
  logic [3:0] r_gap_cnt;
  logic [7:0] r_frame_cnt;

  logic [5:0] w_sum;
  logic       w_c_out;
  logic       w_is_last;

  // --------------------------------------------------------------------------
  // Datapath: adder on registered operands, bit picked by the mux
  // --------------------------------------------------------------------------
  fulladd6 u_add (
    .a     (r_a),
    .b     (r_b),
    .c_in  (r_c_in),
    .sum   (w_sum),
    .c_out (w_c_out)
  );

  // ser_data is purely combinational from held operands and select, so it is
  // stable for as long as the sink holds ser_ready low.
  mux u_mux (
    .d   ({w_c_out, w_sum}),
    .sel (r_sel),
    .y   (ser_data)
  );

  assign w_is_last = (r_sel == c_last_sel);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state logic; abort outranks the serial handshake
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        // abort is ignored here: a coincident start is still accepted
        if (start_valid) begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (ser_ready && w_is_last) begin
          if (c_has_gap) begin
            w_state_nxt = ST_GAP;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (abort || (r_gap_cnt == 4'd0)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Operand, select, gap and frame counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= 6'd0;
      r_b         <= 6'd0;
      r_c_in      <= 1'b0;
      r_sel       <= 3'd0;
      r_gap_cnt   <= 4'd0;
      r_frame_cnt <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_valid) begin
            r_a    <= a;
            r_b    <= b;
            r_c_in <= c_in;
            r_sel  <= 3'd0;
          end
        end
        ST_SHIFT: begin
          // operands are kept on abort; only the select rewinds
          if (abort) begin
            r_sel <= 3'd0;
          end else if (ser_ready) begin
            if (w_is_last) begin
              r_sel       <= 3'd0;
              r_frame_cnt <= r_frame_cnt + 8'd1;
              r_gap_cnt   <= c_gap_load;
            end else begin
              r_sel <= r_sel + 3'd1;
            end
          end
        end
        ST_GAP: begin
          if (abort) begin
            r_gap_cnt <= 4'd0;
          end else if (r_gap_cnt != 4'd0) begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
          end
        end
        default: begin
          r_sel <= 3'd0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign start_ready = (r_state == ST_IDLE);
  assign ser_valid   = (r_state == ST_SHIFT);
  assign ser_last    = (r_state == ST_SHIFT) && w_is_last;
  assign sel_q       = r_sel;
  assign frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire
